// File: rtl/reduce_arb_pkg.sv
// Shared types and helpers for the reduce-tree arbiter.
// Holds the FSM state enum, tag width and round-robin pick.
package reduce_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns {found, index}; scans from ptr upward, wrapping at n.
    function automatic logic [3:0] rr_next(
        input logic [7:0] vld,
        input logic [2:0] ptr,
        input int         n
    );
        logic [3:0] pick;
        int         idx;
        pick = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (vld[idx[2:0]]) begin
                    pick = {1'b1, idx[2:0]};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reduce_tag_fifo.sv
// In-order FIFO of job-owner tags.
// Push is ignored when full, pop is ignored when empty.
module reduce_tag_fifo
    import reduce_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [W-1:0]           tag_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Occupancy is unchanged when a push and a pop coincide
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer, count and storage update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= tag_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/reduce_tree_arbiter.sv
// Round-robin job arbiter in front of a shared FP reduce tree.
// Define REDUCE_ARB_STATS_EN to add job/beat counters and orphan flag.
module reduce_tree_arbiter
    import reduce_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int NUM_FP_POINTS   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_REQ*NUM_FP_POINTS*32-1:0]   req_vector,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_last,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_FP_POINTS*32-1:0]           tree_vector,
    output logic                                  tree_valid,
    output logic                                  tree_last,
    input  logic                                  tree_ready,
    input  logic [31:0]                           tree_result,
    input  logic                                  tree_result_valid,
    output logic                                  tree_result_ready,
    output logic [31:0]                           res_data,
    output logic [NUM_REQ-1:0]                    res_valid,
    input  logic [NUM_REQ-1:0]                    res_ready
`ifdef REDUCE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                 stat_jobs,
    output logic [31:0]                           stat_beats,
    output logic                                  err_orphan_result
`endif
);

    localparam int VW    = NUM_FP_POINTS * 32;
    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int CW    = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e       state_q;
    logic [TAG_W-1:0] grant_q;
    logic [TAG_W-1:0] rr_ptr_q;
    logic [TAG_W-1:0] grant_d;
    logic [TAG_W-1:0] rr_ptr_d;
    logic [3:0]       pick;
    logic             lock;
    logic             push;
    logic             pop;
    logic             xfer;
    logic [TAG_W-1:0] head;
    logic [CW-1:0]    tag_cnt;
    logic             tag_empty;
    logic             tag_full;
    logic             tag_room;

    assign pick     = rr_next(8'(req_valid), 3'(rr_ptr_q), NUM_REQ);
    assign grant_d  = TAG_W'(pick[2:0]);
    assign lock     = (state_q == ARB_LOCK);
    assign tag_room = !tag_full && (tag_cnt < CW'(MAX_OUTSTANDING));
    assign push     = !lock && pick[3] && tag_room;
    assign rr_ptr_d = (grant_q == TAG_W'(NUM_REQ - 1)) ? '0
                    : grant_q + TAG_W'(1);

    assign tree_vector = req_vector[int'(grant_q)*VW +: VW];
    assign tree_valid  = lock && req_valid[grant_q];
    assign tree_last   = lock && req_last[grant_q];
    assign xfer        = tree_valid && tree_ready;

    // Only the locked requester sees the tree's ready
    always_comb begin
        req_ready = '0;
        if (lock) begin
            req_ready[grant_q] = tree_ready;
        end
    end

    // Grant FSM: pick in IDLE, hold the tree until the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (push) begin
                        grant_q <= grant_d;
                        state_q <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (xfer && tree_last) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    reduce_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (TAG_W)
    ) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .tag_i   (grant_d),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (tag_cnt),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    assign res_data          = tree_result;
    assign tree_result_ready = !tag_empty && res_ready[head];
    assign pop               = tree_result_valid && tree_result_ready;

    // Results go to the owner of the oldest outstanding job
    always_comb begin
        res_valid = '0;
        if (tree_result_valid && !tag_empty) begin
            res_valid[head] = 1'b1;
        end
    end

`ifdef REDUCE_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] jobs_q;
    logic [31:0]           beats_q;
    logic                  orphan_q;

    // Per-requester grants, total beats, sticky orphan-result flag
    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_q   <= '0;
            beats_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            if (push) begin
                jobs_q[int'(grant_d)*32 +: 32] <=
                    jobs_q[int'(grant_d)*32 +: 32] + 32'd1;
            end
            if (xfer) begin
                beats_q <= beats_q + 32'd1;
            end
            if (tree_result_valid && tag_empty) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign stat_jobs         = jobs_q;
    assign stat_beats        = beats_q;
    assign err_orphan_result = orphan_q;
`endif

endmodule

// File: doc/reduce_tree_arbiter.md
# reduce_tree_arbiter

Shares one FP adders reduce tree (NUM_FP_POINTS-wide vector input, scalar aggregated output) between NUM_REQ requesters, typically several DT engine cores. It grants the tree for whole reduction jobs (first beat through the `last` beat) in round-robin order. It records the owner of each job in an in-order tag FIFO and routes each returning aggregated result back to the requester that issued the job. It sits directly in front of the reduce tree, and the tree's handshakes connect to it unmodified.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- NUM_FP_POINTS, 8: FP32 lanes per vector beat
- MAX_OUTSTANDING, 4: depth of the tag FIFO, i.e. the maximum number of granted jobs whose result has not yet returned (power of 2)

Ports:
- clk, in, 1: single clock
- rst, in, 1: reset, synchronous, active-high
- req_vector, in, NUM_REQ*NUM_FP_POINTS*32: requester k owns slice k
- req_valid / req_last, in, NUM_REQ: per-requester beat valid / last beat of job
- req_ready, out, NUM_REQ: per-requester beat accept
- tree_vector, out, NUM_FP_POINTS*32: vector to the tree
- tree_valid / tree_last, out, 1: beat valid / last to the tree
- tree_ready, in, 1: tree accepts beat
- tree_result, in, 32: aggregated FP32 result
- tree_result_valid, in, 1: result valid
- tree_result_ready, out, 1: result accept
- res_data, out, 32: routed result, shared by all requesters
- res_valid, out, NUM_REQ: one-hot result valid
- res_ready, in, NUM_REQ: per-requester result accept

## Operation
- FSM states are IDLE and LOCK.
- IDLE: search req_valid round-robin starting at rr_ptr.
  - If a candidate g exists and the tag FIFO count < MAX_OUTSTANDING, register grant=g, push tag g, and go to LOCK.
  - No beat transfers in IDLE. All req_ready are 0 and tree_valid is 0.
- LOCK: tree_vector/tree_valid/tree_last mux combinationally from requester `grant`. req_ready[grant] = tree_ready, and every other req_ready is 0.
  - A beat transfers when tree_valid && tree_ready.
  - When a transferring beat has tree_last=1, go to IDLE and set rr_ptr = (grant+1) mod NUM_REQ.
- Grant is never revoked mid-job. A requester that drops valid mid-job only stalls the tree.
- Result path: head = tag FIFO head.
  - res_valid[k] = tree_result_valid && !fifo_empty && head==k.
  - res_data = tree_result.
  - tree_result_ready = !fifo_empty && res_ready[head].
  - The tag pops on tree_result_valid && tree_result_ready.
- Results return in grant order (the tree is in-order). A stalled head requester blocks all later results (head-of-line blocking is accepted).
- A result arriving with the tag FIFO empty is held, with tree_result_ready=0. This is a protocol error; see the error flag under Configuration.
- When push and pop occur in the same cycle, the count is unchanged. The full check uses the pre-pop count, so there is no bypass.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, tag FIFO empty.
  - req_ready=0, tree_valid=0, tree_last=0, res_valid=0, tree_result_ready=0.
  - tree_vector and res_data are don't-care but driven by the mux.
- Arbitration latency: one cycle. A request seen in IDLE at cycle t allows its first beat at t+1 at the earliest.
- Job-to-job gap is one IDLE bubble cycle minimum.
- Beat path and result path are combinational, with zero added latency.
- Reset mid-job: the FSM and FIFO clear immediately and the partial job is abandoned. The reduce tree must share the same reset.

## Configuration
- REDUCE_ARB_STATS_EN defined adds the following outputs, all cleared by rst:
  - stat_jobs [NUM_REQ*32]: per-requester granted-job counters, wrapping.
  - stat_beats [32]: total beats transferred.
  - err_orphan_result [1]: sticky, set when tree_result_valid is seen with the tag FIFO empty.
- Undefined: the ports and logic above are absent, and behaviour is otherwise identical.

## Structure
- Package reduce_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCK)
  - the TAG_W = $clog2(NUM_REQ) function
  - the round-robin next-grant function
- Sub-module reduce_tag_fifo: register-array FIFO of TAG_W-bit tags with push, pop, head, count, empty, full outputs, synchronous active-high reset.

## Test plan
- Requester 2 sends a 3-beat job while the others are idle, with the tree result stubbed to return 0x40400000. Required response: the tree sees 3 beats with last on beat 3, and res_valid=4'b0100 with res_data=0x40400000.
- All 4 requesters present 1-beat jobs with rr_ptr=0. Required response: grants are 0,1,2,3 with one bubble between jobs, and results route to 0,1,2,3 in order.
- tree_ready is held low for 5 cycles in the middle of requester 1's job. Required response: req_ready[1]=0 for those cycles, and no beat is lost or duplicated (check the beat count and data).
- MAX_OUTSTANDING=2 with results withheld, and three jobs requested. Required response: the third grant occurs only in the cycle after the first result pops.
- res_ready[0]=0 while requester 0's result is at the head. Required response: tree_result_ready=0, and requester 3's queued result waits until res_ready[0]=1.
- rst pulses during beat 2 of a 4-beat job. Required response: all outputs return to their reset values, and a new job from requester 1 then proceeds normally. With REDUCE_ARB_STATS_EN, stat_jobs[1] reads 1.
